ps2_digit_event_fifo: RTL and testbench

//  Parametrised successor to the combinational scancode-to-digit decoder.

---
 rtl/ps2_digit_event_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_digit_event_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_digit_event_fifo.sv
// ps2_digit_event_fifo
//   Decodes a PS/2 scancode-set-2 byte stream into digit make/break events.
//   The E0/F0 prefixes are tracked by a small FSM. Decoded events are queued
//   in an output FIFO with a valid/ready handshake. A held-key bitmap is kept
//   alongside the FIFO.
//
// Parameters
//   DEPTH    output FIFO entries (power of 2, >= 2)
//   KEYPAD   1: keypad codes also decode as digits 0-9
//   TIMEOUT  idle cycles after which a pending prefix is abandoned (>= 2)
//
// Ports
//   clk        rising-edge clock
//   areset_n   asynchronous active-low reset
//   in_valid   in_byte valid this cycle (no backpressure)
//   in_byte    scancode byte
//   out_valid  FIFO head valid
//   out_ready  consumer accepts head when out_valid & out_ready
//   out_digit  head digit 0-9 (0 when empty)
//   out_brk    head is a break event (0 when empty)
//   held       bit d set while digit d is pressed
//   overflow   sticky flag: an event was dropped on a full FIFO
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   timeout    one-cycle pulse when a pending prefix is abandoned
module ps2_digit_event_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned KEYPAD  = 1,
    parameter int unsigned TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_brk,
    output logic [9:0] held,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } state_t;

    state_t        r_state;
    state_t        w_state_eff;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic          w_expire;

    logic          w_hit;
    logic [3:0]    w_digit;
    logic          w_push;
    logic          w_push_brk;

    logic [3:0]    r_mem_digit [DEPTH];
    logic          r_mem_brk   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;

    logic [9:0]    r_held;
    logic          r_overflow;

    // Scancode to digit lookup; w_hit flags a digit code.
    always_comb begin
        w_hit   = 1'b1;
        w_digit = 4'd0;
        case (in_byte)
            8'h45: w_digit = 4'd0;
            8'h16: w_digit = 4'd1;
            8'h1E: w_digit = 4'd2;
            8'h26: w_digit = 4'd3;
            8'h25: w_digit = 4'd4;
            8'h2E: w_digit = 4'd5;
            8'h36: w_digit = 4'd6;
            8'h3D: w_digit = 4'd7;
            8'h3E: w_digit = 4'd8;
            8'h46: w_digit = 4'd9;
            default: begin
                w_hit = 1'b0;
                if (KEYPAD != 0) begin
                    w_hit = 1'b1;
                    case (in_byte)
                        8'h70: w_digit = 4'd0;
                        8'h69: w_digit = 4'd1;
                        8'h72: w_digit = 4'd2;
                        8'h7A: w_digit = 4'd3;
                        8'h6B: w_digit = 4'd4;
                        8'h73: w_digit = 4'd5;
                        8'h74: w_digit = 4'd6;
                        8'h6C: w_digit = 4'd7;
                        8'h75: w_digit = 4'd8;
                        8'h7D: w_digit = 4'd9;
                        default: w_hit = 1'b0;
                    endcase
                end
            end
        endcase
    end

    // A byte arriving in the expiry cycle is decoded as if the FSM were
    // already back in IDLE.
    always_comb begin
        w_expire    = (r_state != S_IDLE) && (r_timer == T_LAST);
        w_state_eff = w_expire ? S_IDLE : r_state;
        w_state_nxt = w_state_eff;
        w_push      = 1'b0;
        w_push_brk  = 1'b0;
        if (in_valid) begin
            case (w_state_eff)
                S_IDLE: begin
                    if (in_byte == 8'hF0)      w_state_nxt = S_BRK;
                    else if (in_byte == 8'hE0) w_state_nxt = S_EXT;
                    else                       w_push      = w_hit;
                end
                S_BRK: begin
                    if (in_byte == 8'hE0)      w_state_nxt = S_EXT;
                    else if (in_byte == 8'hF0) w_state_nxt = S_BRK;
                    else begin
                        w_state_nxt = S_IDLE;
                        w_push      = w_hit;
                        w_push_brk  = 1'b1;
                    end
                end
                S_EXT: begin
                    if (in_byte == 8'hF0)      w_state_nxt = S_EXT_BRK;
                    else if (in_byte == 8'hE0) w_state_nxt = S_EXT;
                    else                       w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    if (in_byte == 8'hE0)      w_state_nxt = S_EXT;
                    else if (in_byte == 8'hF0) w_state_nxt = S_EXT_BRK;
                    else                       w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (in_valid || w_expire || (r_state == S_IDLE))
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so a push into a
    // full FIFO is only dropped when there is no simultaneous pop.
    always_comb begin
        w_pop  = (r_count != '0) && out_ready;
        w_full = (r_count == DEPTH_C);
        w_wr   = w_push && (!w_full || w_pop);
        w_drop = w_push && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_digit[r_wr_ptr] <= w_digit;
            r_mem_brk[r_wr_ptr]   <= w_push_brk;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_held     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // held tracks key state even when the event itself is dropped.
            if (w_push) r_held[w_digit] <= !w_push_brk;
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    always_comb begin
        out_valid = (r_count != '0);
        out_digit = out_valid ? r_mem_digit[r_rd_ptr] : 4'd0;
        out_brk   = out_valid ? r_mem_brk[r_rd_ptr]   : 1'b0;
        held      = r_held;
        overflow  = r_overflow;
        timeout   = w_expire;
    end

endmodule

// File: tb/tb_ps2_digit_event_fifo.sv
module tb_ps2_digit_event_fifo;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       areset_n;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_brk;
    logic [9:0] held;
    logic       overflow;
    logic       ovf_clr;
    logic       timeout;

    logic       nk_valid;
    logic [3:0] nk_digit;
    logic       nk_brk;
    logic [9:0] nk_held;
    logic       nk_ovf;
    logic       nk_to;

    int n_assert = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    ps2_digit_event_fifo #(.DEPTH(4), .KEYPAD(1), .TIMEOUT(TO)) u_dut (
        .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_brk(out_brk), .held(held), .overflow(overflow), .ovf_clr(ovf_clr),
        .timeout(timeout)
    );

    ps2_digit_event_fifo #(.DEPTH(4), .KEYPAD(0), .TIMEOUT(TO)) u_nokp (
        .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .in_byte(in_byte),
        .out_valid(nk_valid), .out_ready(1'b1), .out_digit(nk_digit),
        .out_brk(nk_brk), .held(nk_held), .overflow(nk_ovf), .ovf_clr(ovf_clr),
        .timeout(nk_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head is compared with the scoreboard front.
    always @(negedge clk) begin
        if (areset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_event: got digit %0d brk %0b expected none",
                         out_digit, out_brk);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                chk("event", 32'({out_digit, out_brk}), 32'(e));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic expect_ev(input logic [3:0] d, input logic brk);
        sb.push_back({d, brk});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (!out_valid) done = 1'b1;
            else idle(1);
        end
        chk({name, "_empty"}, 32'(out_valid), 32'(0));
        chk({name, "_sb"}, 32'(sb.size()), 32'(0));
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        areset_n  = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_outs", 32'({out_digit, out_brk, overflow, timeout}), 32'(0));
        chk("rst_held", 32'(held), 32'(0));
        @(negedge clk);
        areset_n = 1'b1;
        idle(1);

        // 1: make, then break of key 1
        out_ready = 1'b1;
        expect_ev(4'd1, 1'b0);
        send(8'h16);
        chk("t1_held_set", 32'(held[1]), 32'(1));
        expect_ev(4'd1, 1'b1);
        send(8'hF0);
        send(8'h16);
        chk("t1_held_clr", 32'(held[1]), 32'(0));
        drain("t1");

        // 2: extended codes never decode; keypad only when enabled
        send(8'hE0); send(8'h70);
        send(8'hE0); send(8'hF0); send(8'h70);
        send(8'hE0); send(8'hE0); send(8'h16);
        idle(2);
        chk("t2_ext_held", 32'(held), 32'(0));
        chk("t2_ext_none", 32'(out_valid), 32'(0));
        expect_ev(4'd0, 1'b0);
        send(8'h70);
        chk("t2_kp_held", 32'(held), 32'h001);
        idle(1);
        chk("t2_nokp_valid", 32'(nk_valid), 32'(0));
        chk("t2_nokp_held", 32'(nk_held), 32'(0));
        expect_ev(4'd0, 1'b1);
        send(8'hF0); send(8'hF0); send(8'h70);
        drain("t2");
        chk("t2_kp_rel", 32'(held), 32'(0));

        // 3: overflow with six makes into a 4-deep FIFO
        out_ready = 1'b0;
        expect_ev(4'd0, 1'b0); send(8'h45);
        expect_ev(4'd1, 1'b0); send(8'h16);
        expect_ev(4'd2, 1'b0); send(8'h1E);
        expect_ev(4'd3, 1'b0); send(8'h26);
        chk("t3_no_ovf_yet", 32'(overflow), 32'(0));
        send(8'h25);
        send(8'h2E);
        chk("t3_ovf", 32'(overflow), 32'(1));
        chk("t3_held", 32'(held), 32'h03F);
        chk("t3_head", 32'({out_digit, out_brk}), 32'({4'd0, 1'b0}));
        clear_ovf();
        chk("t3_ovf_clr", 32'(overflow), 32'(0));
        drain("t3");

        // 4: full FIFO, push and pop in the same cycle
        out_ready = 1'b0;
        expect_ev(4'd6, 1'b0); send(8'h36);
        expect_ev(4'd7, 1'b0); send(8'h3D);
        expect_ev(4'd8, 1'b0); send(8'h3E);
        expect_ev(4'd9, 1'b0); send(8'h46);
        out_ready = 1'b1;
        expect_ev(4'd1, 1'b0);
        send(8'h16);
        out_ready = 1'b0;
        chk("t4_no_ovf", 32'(overflow), 32'(0));
        idle(2);
        chk("t4_head_stable", 32'({out_digit, out_brk}), 32'({4'd7, 1'b0}));
        send(8'h25);
        chk("t4_still_full", 32'(overflow), 32'(1));
        chk("t4_held", 32'(held), 32'h3FF);
        clear_ovf();
        drain("t4");

        // 5: prefix timeout and its boundaries
        send(8'hF0);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= int'(TO) + 3; i++) begin
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        @(posedge clk);
        #1;
        chk("t5_pulses", 32'(pulses), 32'(1));
        chk("t5_pulse_at", 32'(first), 32'(TO));
        expect_ev(4'd0, 1'b0);
        send(8'h45);
        chk("t5_held0", 32'(held[0]), 32'(1));
        expect_ev(4'd1, 1'b1);
        send(8'hF0);
        idle(int'(TO) - 2);
        send(8'h16);
        chk("t5_late_brk", 32'(held[1]), 32'(0));
        expect_ev(4'd1, 1'b0);
        send(8'hF0);
        idle(int'(TO) - 1);
        send(8'h16);
        chk("t5_expired_make", 32'(held[1]), 32'(1));
        drain("t5");

        // 6: asynchronous reset mid-stream
        out_ready = 1'b0;
        send(8'h3D);
        send(8'h46);
        send(8'hF0);
        chk("t6_pre_valid", 32'(out_valid), 32'(1));
        areset_n = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(out_valid), 32'(0));
        chk("t6_rst_outs", 32'({out_digit, out_brk, overflow, timeout}), 32'(0));
        chk("t6_rst_held", 32'(held), 32'(0));
        @(negedge clk);
        areset_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        expect_ev(4'd8, 1'b0);
        send(8'h3E);
        chk("t6_held", 32'(held), 32'h100);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
